// File: rtl/f_npc_fd_reg.sv
// Fetch-side PC register, next-PC select and F/D pipeline register with delay-slot nullify.
// Optional redirect/nullify trace counters are built only when NPC_TRACE_EN is defined.
module f_npc_fd_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFF
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        stall_i,
    input  logic [31:0] f_instr_i,
    input  logic [1:0]  d_npc_op_i,
    input  logic        d_branch_i,
    input  logic        d_cleardb_i,
    input  logic [31:0] d_rs_i,
    output logic [31:0] f_pc_o,
    output logic [31:0] d_instr_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc8_o,
    output logic        d_valid_o,
    output logic        d_exc_adel_o,
    output logic [31:0] trc_taken_o,
    output logic [31:0] trc_kill_o
);

    typedef enum logic {StBoot, StRun} state_e;

    state_e      state_q;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_instr_q, d_pc_q, d_pc8_q;
    logic        d_valid_q, d_exc_adel_q;
    logic [31:0] br_off;
    logic        fetch_bad;

    assign br_off    = {{14{d_instr_q[15]}}, d_instr_q[15:0], 2'b00};
    assign fetch_bad = (f_pc_q[1:0] != 2'b00) || (f_pc_q < TEXT_LO) || (f_pc_q > TEXT_HI);

    // Redirect targets depend only on D fields, so they land after the slot already in F.
    always_comb begin
        f_pc_d = f_pc_q + 32'd4;
        unique case (d_npc_op_i)
            2'd1:    if (d_branch_i) f_pc_d = d_pc_q + 32'd4 + br_off;
            2'd2:    f_pc_d = {d_pc_q[31:28], d_instr_q[25:0], 2'b00};
            2'd3:    f_pc_d = d_rs_i;
            default: f_pc_d = f_pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StBoot;
            f_pc_q       <= PC_RESET;
            d_instr_q    <= '0;
            d_pc_q       <= '0;
            d_pc8_q      <= 32'd8;
            d_valid_q    <= 1'b0;
            d_exc_adel_q <= 1'b0;
        end else if (!stall_i) begin
            unique case (state_q)
                StBoot: begin
                    state_q      <= StRun;
                    d_instr_q    <= '0;
                    d_valid_q    <= 1'b0;
                    d_exc_adel_q <= 1'b0;
                end
                StRun: begin
                    f_pc_q  <= f_pc_d;
                    d_pc_q  <= f_pc_q;
                    d_pc8_q <= f_pc_q + 32'd8;
                    if (d_cleardb_i) begin
                        d_instr_q    <= '0;
                        d_valid_q    <= 1'b0;
                        d_exc_adel_q <= 1'b0;
                    end else if (fetch_bad) begin
                        d_instr_q    <= '0;
                        d_valid_q    <= 1'b1;
                        d_exc_adel_q <= 1'b1;
                    end else begin
                        d_instr_q    <= f_instr_i;
                        d_valid_q    <= 1'b1;
                        d_exc_adel_q <= 1'b0;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign f_pc_o       = f_pc_q;
    assign d_instr_o    = d_instr_q;
    assign d_pc_o       = d_pc_q;
    assign d_pc8_o      = d_pc8_q;
    assign d_valid_o    = d_valid_q;
    assign d_exc_adel_o = d_exc_adel_q;

`ifdef NPC_TRACE_EN
    logic [31:0] trc_taken_q, trc_kill_q;
    logic        adv, taken;

    assign adv   = !stall_i && (state_q == StRun);
    assign taken = (d_npc_op_i == 2'd1 && d_branch_i) || d_npc_op_i[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            trc_taken_q <= '0;
            trc_kill_q  <= '0;
        end else if (adv) begin
            if (taken && trc_taken_q != 32'hFFFF_FFFF) trc_taken_q <= trc_taken_q + 32'd1;
            if (d_cleardb_i && trc_kill_q != 32'hFFFF_FFFF) trc_kill_q <= trc_kill_q + 32'd1;
        end
    end

    assign trc_taken_o = trc_taken_q;
    assign trc_kill_o  = trc_kill_q;
`else
    assign trc_taken_o = '0;
    assign trc_kill_o  = '0;
`endif

endmodule

// File: tb/tb_f_npc_fd_reg.sv
// Self-checking bench for f_npc_fd_reg: directed scenarios plus randomized run vs. a cycle model.
module tb_f_npc_fd_reg;

    localparam logic [31:0] LO  = 32'h0000_3000;
    localparam logic [31:0] HI  = 32'h0000_6FFF;
    localparam logic [31:0] PCR = 32'h0000_3000;
`ifdef NPC_TRACE_EN
    localparam bit TRC = 1'b1;
`else
    localparam bit TRC = 1'b0;
`endif

    logic        clk_i, reset_n_i, stall_i, d_branch_i, d_cleardb_i;
    logic [31:0] f_instr_i, d_rs_i;
    logic [1:0]  d_npc_op_i;
    logic [31:0] f_pc_o, d_instr_o, d_pc_o, d_pc8_o, trc_taken_o, trc_kill_o;
    logic        d_valid_o, d_exc_adel_o;

    f_npc_fd_reg dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .stall_i     (stall_i),
        .f_instr_i   (f_instr_i),
        .d_npc_op_i  (d_npc_op_i),
        .d_branch_i  (d_branch_i),
        .d_cleardb_i (d_cleardb_i),
        .d_rs_i      (d_rs_i),
        .f_pc_o      (f_pc_o),
        .d_instr_o   (d_instr_o),
        .d_pc_o      (d_pc_o),
        .d_pc8_o     (d_pc8_o),
        .d_valid_o   (d_valid_o),
        .d_exc_adel_o(d_exc_adel_o),
        .trc_taken_o (trc_taken_o),
        .trc_kill_o  (trc_kill_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [4096];

    // Reference model state
    bit          m_boot;
    logic [31:0] m_pc, m_dinstr, m_dpc, m_dpc8, m_taken, m_kill;
    bit          m_dvalid, m_dadel;

    function automatic logic [31:0] im(input logic [31:0] a);
        logic [11:0] idx;
        if (a >= LO && a <= HI) begin
            idx = 12'((a - LO) >> 2);
            return mem[idx];
        end
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_pc = PCR; m_dinstr = '0; m_dpc = '0; m_dpc8 = 32'd8;
        m_dvalid = 1'b0; m_dadel = 1'b0; m_taken = '0; m_kill = '0;
    endtask

    task automatic model_clock(input bit st, input logic [1:0] op, input bit br, input bit clr,
                               input logic [31:0] rs);
        logic [31:0] npc, off;
        bit          taken, ok;
        if (st) return;
        if (m_boot) begin
            m_boot = 1'b0; m_dinstr = '0; m_dvalid = 1'b0; m_dadel = 1'b0;
            return;
        end
        off   = {{16{m_dinstr[15]}}, m_dinstr[15:0]};
        taken = (op == 2'd1 && br) || op >= 2'd2;
        case (op)
            2'd1:    npc = br ? m_dpc + 32'd4 + off * 32'd4 : m_pc + 32'd4;
            2'd2:    npc = (m_dpc & 32'hF000_0000) | ((m_dinstr & 32'h03FF_FFFF) * 32'd4);
            2'd3:    npc = rs;
            default: npc = m_pc + 32'd4;
        endcase
        ok = (m_pc % 4 == 0) && m_pc >= LO && m_pc <= HI;
        if (clr) begin
            m_dinstr = '0; m_dvalid = 1'b0; m_dadel = 1'b0;
        end else if (!ok) begin
            m_dinstr = '0; m_dvalid = 1'b1; m_dadel = 1'b1;
        end else begin
            m_dinstr = im(m_pc); m_dvalid = 1'b1; m_dadel = 1'b0;
        end
        m_dpc  = m_pc;
        m_dpc8 = m_pc + 32'd8;
        m_pc   = npc;
        if (TRC && taken && m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 32'd1;
        if (TRC && clr && m_kill != 32'hFFFF_FFFF) m_kill = m_kill + 32'd1;
    endtask

    // One clock: drive at negedge, advance model at posedge, return at the next negedge.
    task automatic step(input bit st, input logic [1:0] op, input bit br, input bit clr,
                        input logic [31:0] rs);
        stall_i = st; d_npc_op_i = op; d_branch_i = br; d_cleardb_i = clr; d_rs_i = rs;
        f_instr_i = im(m_pc);
        @(posedge clk_i);
        model_clock(st, op, br, clr, rs);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0; stall_i = 1'b0; d_npc_op_i = 2'd0; d_branch_i = 1'b0;
        d_cleardb_i = 1'b0; d_rs_i = '0; f_instr_i = '0;
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        @(posedge clk_i);
        #2;
        stall_i   = 1'b1;
        reset_n_i = 1'b0;
        #1;
        model_reset();
        n_checks++; if (f_pc_o !== PCR) $display("FAIL reset_f_pc: got %h want %h", f_pc_o, PCR); else n_pass++;
        n_checks++; if (d_valid_o !== 1'b0) $display("FAIL reset_d_valid: got %b want 0", d_valid_o); else n_pass++;
        n_checks++; if (d_pc_o !== 32'd0) $display("FAIL reset_d_pc: got %h want 0", d_pc_o); else n_pass++;
        n_checks++; if (d_pc8_o !== 32'd8) $display("FAIL reset_d_pc8: got %h want 8", d_pc8_o); else n_pass++;
        n_checks++; if ({d_instr_o, d_exc_adel_o} !== 33'd0) $display("FAIL reset_instr_adel: got %h/%b want 0/0", d_instr_o, d_exc_adel_o); else n_pass++;
        n_checks++; if ({trc_taken_o, trc_kill_o} !== 64'd0) $display("FAIL reset_counters: got %h/%h want 0/0", trc_taken_o, trc_kill_o); else n_pass++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_valid_o !== 1'b0) $display("FAIL boot_bubble: got %b want 0", d_valid_o); else n_pass++;
        n_checks++; if (f_pc_o !== PCR) $display("FAIL boot_f_pc_hold: got %h want %h", f_pc_o, PCR); else n_pass++;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== PCR) $display("FAIL first_d_pc: got %h want %h", d_pc_o, PCR); else n_pass++;
        n_checks++; if (d_instr_o !== mem[0]) $display("FAIL first_d_instr: got %h want %h", d_instr_o, mem[0]); else n_pass++;
        n_checks++; if (d_valid_o !== 1'b1) $display("FAIL first_d_valid: got %b want 1", d_valid_o); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        mem[1] = 32'h1000_0003;
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== 32'h3004 || f_pc_o !== 32'h3008) $display("FAIL br_setup: got %h/%h want 3004/3008", d_pc_o, f_pc_o); else n_pass++;
        step(1'b0, 2'd1, 1'b1, 1'b0, '0);
        n_checks++; if (f_pc_o !== 32'h3014) $display("FAIL br_target: got %h want 3014", f_pc_o); else n_pass++;
        n_checks++; if (d_pc_o !== 32'h3008 || d_valid_o !== 1'b1) $display("FAIL br_slot: got %h/%b want 3008/1", d_pc_o, d_valid_o); else n_pass++;
        n_checks++; if (trc_taken_o !== 32'(TRC)) $display("FAIL br_trc_taken: got %h want %h", trc_taken_o, 32'(TRC)); else n_pass++;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== 32'h3014 || f_pc_o !== 32'h3018) $display("FAIL br_after: got %h/%h want 3014/3018", d_pc_o, f_pc_o); else n_pass++;
    endtask

    task automatic test_cleardb();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        step(1'b0, 2'd1, 1'b0, 1'b1, '0);
        n_checks++; if (d_pc_o !== 32'h3008 || d_valid_o !== 1'b0 || d_instr_o !== 32'd0) $display("FAIL kill_slot: got %h/%b/%h want 3008/0/0", d_pc_o, d_valid_o, d_instr_o); else n_pass++;
        n_checks++; if (f_pc_o !== 32'h300C) $display("FAIL kill_f_pc: got %h want 300c", f_pc_o); else n_pass++;
        n_checks++; if (trc_kill_o !== 32'(TRC) || trc_taken_o !== 32'd0) $display("FAIL kill_trc: got %h/%h want %h/0", trc_kill_o, trc_taken_o, 32'(TRC)); else n_pass++;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== 32'h300C || d_valid_o !== 1'b1) $display("FAIL kill_after: got %h/%b want 300c/1", d_pc_o, d_valid_o); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 1'b0, 1'b1, '0);
            n_checks++;
            if (f_pc_o !== 32'h3008 || d_pc_o !== 32'h3004 || d_valid_o !== 1'b1 || trc_kill_o !== 32'd0)
                $display("FAIL stall_hold[%0d]: got %h/%h/%b/%h want 3008/3004/1/0", i, f_pc_o, d_pc_o, d_valid_o, trc_kill_o);
            else n_pass++;
        end
        step(1'b0, 2'd0, 1'b0, 1'b1, '0);
        n_checks++; if (d_pc_o !== 32'h3008 || d_valid_o !== 1'b0 || f_pc_o !== 32'h300C) $display("FAIL stall_release: got %h/%b/%h want 3008/0/300c", d_pc_o, d_valid_o, f_pc_o); else n_pass++;
        n_checks++; if (trc_kill_o !== 32'(TRC)) $display("FAIL stall_trc_kill: got %h want %h", trc_kill_o, 32'(TRC)); else n_pass++;
    endtask

    task automatic test_jr_adel();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        step(1'b0, 2'd3, 1'b0, 1'b0, 32'h3002);
        n_checks++; if (f_pc_o !== 32'h3002 || d_pc_o !== 32'h3008) $display("FAIL jr_target: got %h/%h want 3002/3008", f_pc_o, d_pc_o); else n_pass++;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_exc_adel_o !== 1'b1 || d_valid_o !== 1'b1 || d_instr_o !== 32'd0) $display("FAIL jr_adel: got %b/%b/%h want 1/1/0", d_exc_adel_o, d_valid_o, d_instr_o); else n_pass++;
        n_checks++; if (d_pc_o !== 32'h3002 || d_pc8_o !== 32'h300A) $display("FAIL jr_adel_pc: got %h/%h want 3002/300a", d_pc_o, d_pc8_o); else n_pass++;
    endtask

    task automatic test_jump();
        do_reset();
        mem[4] = 32'h0800_0C40;
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== 32'h3010) $display("FAIL j_setup: got %h want 3010", d_pc_o); else n_pass++;
        step(1'b0, 2'd2, 1'b0, 1'b0, '0);
        n_checks++; if (f_pc_o !== 32'h3100) $display("FAIL j_target: got %h want 3100", f_pc_o); else n_pass++;
        n_checks++; if (d_pc_o !== 32'h3014 || d_pc8_o !== 32'h301C) $display("FAIL j_slot: got %h/%h want 3014/301c", d_pc_o, d_pc8_o); else n_pass++;
        step(1'b0, 2'd0, 1'b0, 1'b0, '0);
        n_checks++; if (d_pc_o !== 32'h3100 || d_instr_o !== mem[64]) $display("FAIL j_land: got %h/%h want 3100/%h", d_pc_o, d_instr_o, mem[64]); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] rs;
        bit          st, br, clr;
        int          sel;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            st  = ($urandom_range(0, 99) < 20);
            br  = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 99) < 15);
            op  = m_dvalid ? 2'($urandom_range(0, 3)) : 2'd0;
            sel = $urandom_range(0, 9);
            rs  = LO + 32'($urandom_range(0, 4095)) * 32'd4;
            if (sel == 0) rs = rs | 32'd2;
            if (sel == 1) rs = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            step(st, op, br, clr, rs);
            n_checks++;
            if ({f_pc_o, d_instr_o, d_pc_o, d_pc8_o, d_valid_o, d_exc_adel_o} !==
                {m_pc, m_dinstr, m_dpc, m_dpc8, m_dvalid, m_dadel})
                $display("FAIL rand_pipe[%0d]: got pc=%h instr=%h dpc=%h dpc8=%h v=%b adel=%b want pc=%h instr=%h dpc=%h dpc8=%h v=%b adel=%b",
                         i, f_pc_o, d_instr_o, d_pc_o, d_pc8_o, d_valid_o, d_exc_adel_o,
                         m_pc, m_dinstr, m_dpc, m_dpc8, m_dvalid, m_dadel);
            else n_pass++;
            n_checks++;
            if (trc_taken_o !== m_taken || trc_kill_o !== m_kill)
                $display("FAIL rand_trc[%0d]: got %h/%h want %h/%h", i, trc_taken_o, trc_kill_o, m_taken, m_kill);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            r = r & 32'hFC00_00FF;
            if (r[7]) r = r | 32'h0000_FF00;
            mem[i] = r;
        end
        reset_n_i = 1'b0; stall_i = 1'b0; d_npc_op_i = 2'd0; d_branch_i = 1'b0;
        d_cleardb_i = 1'b0; d_rs_i = '0; f_instr_i = '0;
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        test_reset();
        test_branch();
        test_cleardb();
        test_stall();
        test_jr_adel();
        test_jump();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
